control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit sitting directly upstream of the Mini SRC datapath.
- Generates, cycle by cycle, the strobes for the fetch (T0–T2) and execute (T3–T6) phases. These are the signals the datapath benches currently drive by hand.
- Covers three-register ALU ops, mul/div (LO/HI write-back), nop and halt.
- Includes a memory-ready wait in the fetch read cycle.

Parameters:
- INCPC_OP, 5'b11111, alu_control code for PC+1 used in T0.
- MUL_OP, 5'b01111, opcode (and ALU code) for multiply.
- DIV_OP, 5'b10000, opcode (and ALU code) for divide.
- NOP_OP, 5'b11010, no-operation opcode.
- HALT_OP, 5'b11011, halt opcode.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- ir  in  32  instruction register contents; opcode = ir[31:27].
- start  in  1  leave IDLE/HALT and begin fetch.
- mem_rdy  in  1  memory read data valid.
- Pout, MARen, Pen, Read, MDRen, MDROut, IRen, Yen  out  1 each  datapath strobes.
- ZLOen, ZHIen, ZLOout, ZHIout, LOen, HIen  out  1 each  Z/LO/HI strobes.
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-field select and general-register in/out.
- alu_control  out  5  ALU operation code.
- run  out  1  high while sequencing.
- illegal  out  1  high during T3 of an undefined opcode.

Behaviour:
- State register: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. Outputs are a pure decode of the state plus ir[31:27] (Moore-style).
- Any output not listed for a state is 0. alu_control defaults to 5'b00000.
- Reset: clr=0 forces IDLE asynchronously. All outputs are 0 immediately, including mid-instruction. There is no partial write-back after reset.
- IDLE: run=0. start=1 moves to T0; otherwise stays in IDLE.
- T0: Pout, MARen, ZLOen, alu_control=INCPC_OP. Next state T1.
- T1: ZLOout, Pen, Read, MDRen held.
  - Stays in T1 while mem_rdy=0, with all strobes held.
  - Moves to T2 on the edge where mem_rdy=1.
- T2: MDROut, IRen. Next state T3. ir is valid from T3 onward.
- T3, by opcode class:
  - ALU class (00000–01110) or MUL_OP/DIV_OP: Grb, Rout, Yen. Next state T4.
  - NOP_OP: no strobes. Next state T0.
  - HALT_OP: no strobes. Next state HALT.
  - Any other opcode: illegal=1, no other strobes. Next state T0 (treated as nop).
- T4:
  - ALU class: Grc, Rout, ZLOen, alu_control=opcode.
  - MUL_OP/DIV_OP: same strobes plus ZHIen.
  - Next state T5.
- T5:
  - ALU class: ZLOout, Gra, Rin. Next state T0.
  - MUL_OP/DIV_OP: ZLOout, LOen. Next state T6.
- T6 (mul/div only): ZHIout, HIen. Next state T0.
- HALT: run=0, no strobes. start=1 moves to T0 (PC already advanced past halt). Otherwise stays in HALT.
- run=1 in every state except IDLE and HALT.
- Instruction latency with mem_rdy tied high: ALU 6 cycles, mul/div 7, nop/illegal 4, halt 4 to reach HALT. Each cycle mem_rdy is held low adds 1.
- start is ignored outside IDLE/HALT.
- Bus exclusivity: at most one of Pout, ZLOout, ZHIout, MDROut, Rout is 1 in any cycle. Must hold for every state/opcode combination.

Test Plan:
1. Reset values: clr=0 mid-T4 of an ALU instruction -> same cycle all outputs 0, state IDLE. After clr=1 and no start -> remains IDLE with run=0.
2. ALU fetch/execute: start pulse, mem_rdy=1, ir=32'h28918000 (opcode 00101) -> six cycles T0..T5 with strobes exactly as listed. alu_control=11111 in T0 and 00101 in T4. Gra+Rin only in T5. Returns to T0.
3. Memory wait: mem_rdy=0 for 3 cycles in T1 -> T1 lasts 4 cycles with ZLOout/Pen/Read/MDRen held. T2 follows the edge where mem_rdy=1.
4. Multiply: ir=32'h78118000 -> T4 asserts ZLOen and ZHIen with alu_control=01111. T5 asserts ZLOout+LOen, T6 asserts ZHIout+HIen. Rin is never asserted. Back to T0 after 7 cycles.
5. Halt/resume: ir=32'hD8000000 -> after T3, HALT with run=0 and no strobes for 10 cycles. start=1 -> T0 next cycle.
6. Illegal and nop: ir=32'hF8000000 -> illegal=1 for exactly the T3 cycle, then T0. ir=32'hD0000000 -> T3 then T0 with illegal=0. Bus-exclusivity assertion checked every cycle across all scenarios.

Source files
------------

// File: rtl/control_sequencer_if.sv
// control_sequencer_if
// Groups the instruction/handshake inputs and every datapath strobe driven by
// the hardwired control unit. The master modport is the sequencer; the slave
// modport is the datapath side (instruction register, memory, register file).
//   ir, start, mem_rdy              : datapath -> sequencer
//   Pout .. Rout, alu_control       : sequencer -> datapath strobes / ALU code
//   run, illegal                    : sequencer status
interface control_sequencer_if;
    logic [31:0] ir;
    logic        start;
    logic        mem_rdy;

    logic        Pout, MARen, Pen, Read, MDRen, MDROut, IRen, Yen;
    logic        ZLOen, ZHIen, ZLOout, ZHIout, LOen, HIen;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic [4:0]  alu_control;
    logic        run;
    logic        illegal;

    modport master (
        input  ir, start, mem_rdy,
        output Pout, MARen, Pen, Read, MDRen, MDROut, IRen, Yen,
        output ZLOen, ZHIen, ZLOout, ZHIout, LOen, HIen,
        output Gra, Grb, Grc, Rin, Rout,
        output alu_control, run, illegal
    );

    modport slave (
        output ir, start, mem_rdy,
        input  Pout, MARen, Pen, Read, MDRen, MDROut, IRen, Yen,
        input  ZLOen, ZHIen, ZLOout, ZHIout, LOen, HIen,
        input  Gra, Grb, Grc, Rin, Rout,
        input  alu_control, run, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
// Hardwired control unit for the Mini SRC datapath. Steps through fetch
// (T0-T2) and execute (T3-T6) and decodes the datapath strobes from the
// current state and the opcode ir[31:27] (Moore style).
//   clk  : system clock, rising edge
//   clr  : asynchronous active-low reset, forces IDLE
//   bus  : control_sequencer_if.master (ir/start/mem_rdy in, strobes out)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, waiting for start
// T0    | PC to MAR, PC+1 computed into ZLO
// T1    | memory read, ZLO back to PC; held until mem_rdy
// T2    | MDR to IR
// T3    | Rb to Y, or nop / halt / illegal resolution
// T4    | Rc through ALU into Z (ZHI too for mul/div)
// T5    | ZLO to Ra (ALU) or to LO (mul/div)
// T6    | ZHI to HI (mul/div only)
// HALT  | stopped after a halt opcode, waiting for start
module control_sequencer #(
    parameter logic [4:0] INCPC_OP = 5'b11111,
    parameter logic [4:0] MUL_OP   = 5'b01111,
    parameter logic [4:0] DIV_OP   = 5'b10000,
    parameter logic [4:0] NOP_OP   = 5'b11010,
    parameter logic [4:0] HALT_OP  = 5'b11011
) (
    input  logic                        clk,
    input  logic                        clr,
    control_sequencer_if.master         bus
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    logic [3:0] state, state_nxt;
    logic [4:0] opcode;
    logic       is_alu, is_muldiv, is_nop, is_halt;
    logic       unused_ir;

    assign opcode    = bus.ir[31:27];
    assign unused_ir = ^bus.ir[26:0];

    assign is_alu    = (opcode <= 5'b01110);
    assign is_muldiv = (opcode == MUL_OP) || (opcode == DIV_OP);
    assign is_nop    = (opcode == NOP_OP);
    assign is_halt   = (opcode == HALT_OP);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_T0;
            S_T0:   state_nxt = S_T1;
            S_T1:   if (bus.mem_rdy) state_nxt = S_T2;
            S_T2:   state_nxt = S_T3;
            S_T3: begin
                // Undefined opcodes fall through to the next fetch like a nop.
                if (is_alu || is_muldiv) state_nxt = S_T4;
                else if (is_halt)        state_nxt = S_HALT;
                else                     state_nxt = S_T0;
            end
            S_T4:   state_nxt = S_T5;
            S_T5:   state_nxt = is_muldiv ? S_T6 : S_T0;
            S_T6:   state_nxt = S_T0;
            S_HALT: if (bus.start) state_nxt = S_T0;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.Pout = 1'b0;  bus.MARen = 1'b0;  bus.Pen = 1'b0;    bus.Read = 1'b0;
        bus.MDRen = 1'b0; bus.MDROut = 1'b0; bus.IRen = 1'b0;   bus.Yen = 1'b0;
        bus.ZLOen = 1'b0; bus.ZHIen = 1'b0;  bus.ZLOout = 1'b0; bus.ZHIout = 1'b0;
        bus.LOen = 1'b0;  bus.HIen = 1'b0;   bus.Gra = 1'b0;    bus.Grb = 1'b0;
        bus.Grc = 1'b0;   bus.Rin = 1'b0;    bus.Rout = 1'b0;
        bus.alu_control = 5'b00000;
        bus.illegal     = 1'b0;
        bus.run         = (state != S_IDLE) && (state != S_HALT);
        case (state)
            S_T0: begin
                bus.Pout = 1'b1; bus.MARen = 1'b1; bus.ZLOen = 1'b1;
                bus.alu_control = INCPC_OP;
            end
            S_T1: begin
                bus.ZLOout = 1'b1; bus.Pen = 1'b1; bus.Read = 1'b1; bus.MDRen = 1'b1;
            end
            S_T2: begin
                bus.MDROut = 1'b1; bus.IRen = 1'b1;
            end
            S_T3: begin
                if (is_alu || is_muldiv) begin
                    bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yen = 1'b1;
                end else if (!is_nop && !is_halt) begin
                    bus.illegal = 1'b1;
                end
            end
            S_T4: begin
                bus.Grc = 1'b1; bus.Rout = 1'b1; bus.ZLOen = 1'b1;
                bus.ZHIen = is_muldiv;
                bus.alu_control = opcode;
            end
            S_T5: begin
                bus.ZLOout = 1'b1;
                if (is_muldiv) begin
                    bus.LOen = 1'b1;
                end else begin
                    bus.Gra = 1'b1; bus.Rin = 1'b1;
                end
            end
            S_T6: begin
                bus.ZHIout = 1'b1; bus.HIen = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
    logic clk = 1'b0;
    logic clr;

    control_sequencer_if bus ();
    control_sequencer dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Packed view of all outputs, LSB first:
    // 0 Pout 1 MARen 2 Pen 3 Read 4 MDRen 5 MDROut 6 IRen 7 Yen 8 ZLOen 9 ZHIen
    // 10 ZLOout 11 ZHIout 12 LOen 13 HIen 14 Gra 15 Grb 16 Grc 17 Rin 18 Rout
    // 23:19 alu_control 24 run 25 illegal
    localparam logic [25:0] M_POUT = 26'd1 << 0,  M_MARE = 26'd1 << 1,  M_PEN = 26'd1 << 2;
    localparam logic [25:0] M_READ = 26'd1 << 3,  M_MDRE = 26'd1 << 4,  M_MDRO = 26'd1 << 5;
    localparam logic [25:0] M_IRE  = 26'd1 << 6,  M_YEN  = 26'd1 << 7,  M_ZLOE = 26'd1 << 8;
    localparam logic [25:0] M_ZHIE = 26'd1 << 9,  M_ZLOO = 26'd1 << 10, M_ZHIO = 26'd1 << 11;
    localparam logic [25:0] M_LOE  = 26'd1 << 12, M_HIE  = 26'd1 << 13, M_GRA  = 26'd1 << 14;
    localparam logic [25:0] M_GRB  = 26'd1 << 15, M_GRC  = 26'd1 << 16, M_RIN  = 26'd1 << 17;
    localparam logic [25:0] M_ROUT = 26'd1 << 18, M_RUN  = 26'd1 << 24, M_ILL  = 26'd1 << 25;

    logic [25:0] exp_q[$];
    int          rdy_q[$];   // mem_rdy to drive in that cycle; -1 = don't care (random)

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [25:0] observed();
        return {bus.illegal, bus.run, bus.alu_control, bus.Rout, bus.Rin, bus.Grc, bus.Grb,
                bus.Gra, bus.HIen, bus.LOen, bus.ZHIout, bus.ZLOout, bus.ZHIen, bus.ZLOen,
                bus.Yen, bus.IRen, bus.MDROut, bus.MDRen, bus.Read, bus.Pen, bus.MARen, bus.Pout};
    endfunction

    function automatic logic [25:0] alu_f(input logic [4:0] c);
        return {2'b00, c, 19'd0};
    endfunction

    function automatic void put(input logic [25:0] v, input int r);
        exp_q.push_back(v);
        rdy_q.push_back(r);
    endfunction

    // Microprogram of one instruction as the datapath should see it, cycle by cycle.
    function automatic void build(input logic [31:0] ins, input int waits);
        logic [4:0] op;
        bit alu, md;
        op  = ins[31:27];
        alu = (op < 5'd15);
        md  = (op == 5'd15) || (op == 5'd16);
        exp_q.delete();
        rdy_q.delete();
        put(M_POUT | M_MARE | M_ZLOE | M_RUN | alu_f(5'b11111), -1);
        for (int k = 0; k <= waits; k++)
            put(M_ZLOO | M_PEN | M_READ | M_MDRE | M_RUN, (k == waits) ? 1 : 0);
        put(M_MDRO | M_IRE | M_RUN, -1);
        if (alu || md) begin
            put(M_GRB | M_ROUT | M_YEN | M_RUN, -1);
            put(M_GRC | M_ROUT | M_ZLOE | (md ? M_ZHIE : 26'd0) | M_RUN | alu_f(op), -1);
            if (md) begin
                put(M_ZLOO | M_LOE | M_RUN, -1);
                put(M_ZHIO | M_HIE | M_RUN, -1);
            end else begin
                put(M_ZLOO | M_GRA | M_RIN | M_RUN, -1);
            end
        end else if (op == 5'd26 || op == 5'd27) begin
            put(M_RUN, -1);
        end else begin
            put(M_ILL | M_RUN, -1);
        end
    endfunction

    task automatic check_cycle(input string tag, input logic [25:0] exp);
        logic [25:0] o;
        o = observed();
        chk(tag, {6'd0, o}, {6'd0, exp});
        chk("bus_excl", {31'd0, ($countones({o[0], o[10], o[11], o[5], o[18]}) <= 1)}, 32'd1);
    endtask

    // Runs one instruction starting in its T0 cycle. abort >= 0 pulls clr low
    // in that cycle (after checking it) and returns.
    task automatic exec(input logic [31:0] ins, input int waits, input int abort);
        logic [4:0] op;
        op = ins[31:27];
        build(ins, waits);
        foreach (exp_q[i]) begin
            @(negedge clk);
            check_cycle($sformatf("op%02h_w%0d_c%0d", op, waits, i), exp_q[i]);
            if (i == 0) bus.ir = ins;
            if (i == abort) begin
                clr = 1'b0;
                #1;
                chk("reset_async", {6'd0, observed()}, 32'd0);
                return;
            end
            bus.mem_rdy = (rdy_q[i] < 0) ? 1'($urandom_range(0, 1)) : rdy_q[i][0];
            bus.start   = 1'($urandom_range(0, 1));
        end
    endtask

    // IDLE or HALT: everything low; optionally pulse start in the last cycle.
    task automatic hold(input int n, input bit go);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_cycle("idle_halt", 26'd0);
            bus.mem_rdy = 1'($urandom_range(0, 1));
            bus.start   = go && (k == n - 1);
        end
    endtask

    task automatic random_run(input int n);
        logic [31:0] r;
        logic [4:0]  op;
        int          cls;
        for (int j = 0; j < n; j++) begin
            r   = $urandom();
            cls = int'($urandom_range(0, 9));
            if (cls <= 3)      op = 5'($urandom_range(0, 14));
            else if (cls == 4) op = 5'd15;
            else if (cls == 5) op = 5'd16;
            else if (cls == 6) op = 5'd26;
            else if (cls == 7) op = 5'd27;
            else begin
                op = 5'($urandom_range(17, 31));
                while (op == 5'd26 || op == 5'd27) op = 5'($urandom_range(17, 31));
            end
            r[31:27] = op;
            exec(r, int'($urandom_range(0, 3)), -1);
            if (op == 5'd27) hold(int'($urandom_range(1, 4)), 1'b1);
        end
    endtask

    initial begin
        int w;
        clr = 1'b0;
        bus.ir = 32'd0;
        bus.start = 1'b0;
        bus.mem_rdy = 1'b0;
        #3;
        chk("reset_outputs", {6'd0, observed()}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        hold(3, 1'b1);

        exec(32'h28918000, 0, -1);   // ALU opcode 00101
        exec(32'h28918000, 3, -1);   // memory wait of 3 cycles
        exec(32'h78118000, 0, -1);   // multiply
        exec(32'h80000000, 1, -1);   // divide
        exec(32'hF8000000, 0, -1);   // illegal
        exec(32'hD0000000, 2, -1);   // nop
        exec(32'hD8000000, 0, -1);   // halt
        hold(10, 1'b1);

        random_run(60);

        // Reset in the middle of T4 of an ALU instruction.
        w = int'($urandom_range(0, 2));
        exec(32'h28918000, w, w + 4);
        @(negedge clk);
        chk("reset_held", {6'd0, observed()}, 32'd0);
        clr = 1'b1;
        bus.start = 1'b0;
        hold(5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
